// File: rtl/iter_shift_unit.sv
// Multi-cycle shift/rotate unit: shifts by up to STEP bit positions per clock.
// Start/busy/done handshake; result is held until the next accepted start.
module iter_shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             zero
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W:0] STEP_C = (CNT_W+1)'(STEP);

    localparam logic [2:0] OP_SHR  = 3'b000;
    localparam logic [2:0] OP_SHRA = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] step_k;
    logic [CNT_W-1:0] cnt_in;
    logic             unused_b_hi;

    // Rotates use a doubled copy of the operand so no subtraction is needed.
    function automatic logic [WIDTH-1:0] shift_by(input logic [2:0]       op_f,
                                                  input logic [WIDTH-1:0] val,
                                                  input logic [CNT_W-1:0] k);
        logic [2*WIDTH-1:0] ror_v;
        logic [2*WIDTH-1:0] rol_v;
        ror_v = {val, val} >> k;
        rol_v = {val, val} << k;
        case (op_f)
            OP_SHR:  shift_by = val >> k;
            OP_SHRA: shift_by = $unsigned($signed(val) >>> k);
            OP_SHL:  shift_by = val << k;
            OP_ROR:  shift_by = ror_v[WIDTH-1:0];
            OP_ROL:  shift_by = rol_v[2*WIDTH-1:WIDTH];
            default: shift_by = val;
        endcase
    endfunction

    function automatic logic is_shift(input logic [2:0] op_f);
        is_shift = (op_f <= OP_ROL);
    endfunction

    assign cnt_in      = b[CNT_W-1:0];
    assign unused_b_hi = ^b[WIDTH-1:CNT_W];

    // Positions to shift this cycle: min(STEP, rem).
    always_comb begin
        if ({1'b0, rem_q} < STEP_C) begin
            step_k = rem_q;
        end else begin
            step_k = STEP_C[CNT_W-1:0];
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        result_d = result_q;
        rem_d    = rem_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    op_d     = op;
                    result_d = a;
                    rem_d    = cnt_in;
                    if ((cnt_in != {CNT_W{1'b0}}) && is_shift(op)) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                result_d = shift_by(op_q, result_q, step_k);
                rem_d    = rem_q - step_k;
                if (rem_q == step_k) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; clear aborts any operation in flight.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q  <= S_IDLE;
            op_q     <= 3'b000;
            result_q <= {WIDTH{1'b0}};
            rem_q    <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            result_q <= result_d;
            rem_q    <= rem_d;
        end
    end

    assign result = result_q;
    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign zero   = (result_q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_iter_shift_unit.sv
// Self-checking bench for iter_shift_unit: STEP=1 and STEP=4 instances, WIDTH=32,
// expected results queued at stimulus time and compared when done rises.
module tb_iter_shift_unit;
    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic        sel   = 1'b0;
    logic [2:0]  op    = 3'b000;
    logic [31:0] a     = 32'd0;
    logic [31:0] b     = 32'd0;

    logic        start1, start4;
    logic [31:0] result1, result4;
    logic        busy1, busy4, done1, done4, zero1, zero4;
    logic [31:0] result_x;
    logic        busy_x, done_x, zero_x;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];

    assign start1   = start && !sel;
    assign start4   = start && sel;
    assign result_x = sel ? result4 : result1;
    assign busy_x   = sel ? busy4 : busy1;
    assign done_x   = sel ? done4 : done1;
    assign zero_x   = sel ? zero4 : zero1;

    iter_shift_unit #(.WIDTH(32), .STEP(1)) u_step1 (
        .clock(clock), .clear(clear), .start(start1), .op(op), .a(a), .b(b),
        .result(result1), .busy(busy1), .done(done1), .zero(zero1)
    );

    iter_shift_unit #(.WIDTH(32), .STEP(4)) u_step4 (
        .clock(clock), .clear(clear), .start(start4), .op(op), .a(a), .b(b),
        .result(result4), .busy(busy4), .done(done4), .zero(zero4)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] cnt_b);
        int c;
        c = int'(cnt_b[4:0]);
        case (o)
            3'd0: model = x >> c;
            3'd1: model = $unsigned($signed(x) >>> c);
            3'd2: model = x << c;
            3'd3: model = (c == 0) ? x : ((x >> c) | (x << (32 - c)));
            3'd4: model = (c == 0) ? x : ((x << c) | (x >> (32 - c)));
            default: model = x;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] o, input logic [31:0] cnt_b, input int step);
        int c;
        c = int'(cnt_b[4:0]);
        if (o <= 3'd4 && c != 0) lat_of = (c + step - 1) / step + 1;
        else lat_of = 1;
    endfunction

    task automatic run_op(input logic s, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] expv, input bit interfere, input string name);
        int edges;
        int busy_n;
        logic [31:0] e;
        int el;
        sel = s;
        @(negedge clock);
        op = o; a = x; b = y; start = 1'b1;
        exp_q.push_back(expv);
        lat_q.push_back(lat_of(o, y, s ? 4 : 1));
        @(posedge clock); #1;
        start = 1'b0;
        edges = 1;
        busy_n = 0;
        while (!done_x && edges < 200) begin
            if (busy_x) busy_n++;
            if (interfere && edges == 2) begin
                start = 1'b1; op = 3'b011; a = $urandom; b = 32'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clock); #1;
            edges++;
        end
        start = 1'b0;
        e  = exp_q.pop_front();
        el = lat_q.pop_front();
        checks++;
        if (done_x !== 1'b1) begin
            $display("FAIL %s timeout: done not seen after %0d edges", name, edges);
            errors++;
        end
        checks++;
        if (result_x !== e) begin
            $display("FAIL %s result: got %h expected %h", name, result_x, e);
            errors++;
        end
        checks++;
        if (zero_x !== (e == 32'd0)) begin
            $display("FAIL %s zero: got %b expected %b", name, zero_x, (e == 32'd0));
            errors++;
        end
        checks++;
        if (edges != el) begin
            $display("FAIL %s latency: got %0d expected %0d", name, edges, el);
            errors++;
        end
        checks++;
        if (busy_n != el - 1) begin
            $display("FAIL %s busy cycles: got %0d expected %0d", name, busy_n, el - 1);
            errors++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (result1 !== 32'd0 || busy1 !== 1'b0 || done1 !== 1'b0 || zero1 !== 1'b1) begin
            $display("FAIL reset step1: got r=%h b=%b d=%b z=%b expected r=0 b=0 d=0 z=1", result1, busy1, done1, zero1);
            errors++;
        end
        checks++;
        if (result4 !== 32'd0 || busy4 !== 1'b0 || done4 !== 1'b0 || zero4 !== 1'b1) begin
            $display("FAIL reset step4: got r=%h b=%b d=%b z=%b expected r=0 b=0 d=0 z=1", result4, busy4, done4, zero4);
            errors++;
        end
    endtask

    task automatic test_shifts();
        run_op(1'b0, 3'd0, 32'hFFFF_FF0A, 32'd7,  32'h01FF_FFFE, 1'b0, "shr_s1");
        run_op(1'b1, 3'd1, 32'hFFFF_FF0A, 32'd7,  32'hFFFF_FFFE, 1'b0, "shra_s4");
        run_op(1'b1, 3'd2, 32'h0000_0001, 32'd31, 32'h8000_0000, 1'b0, "shl_s4");
        run_op(1'b0, 3'd4, 32'h8000_0001, 32'd35, 32'h0000_000C, 1'b0, "rol_s1");
        run_op(1'b0, 3'd3, 32'h0000_0001, 32'd1,  32'h8000_0000, 1'b0, "ror_s1");
        run_op(1'b1, 3'd3, 32'h1234_5678, 32'd13, model(3'd3, 32'h1234_5678, 32'd13), 1'b0, "ror_s4");
    endtask

    task automatic test_zero_count();
        run_op(1'b0, 3'd0, 32'h0000_0000, 32'd0,  32'h0000_0000, 1'b0, "b0_zero");
        run_op(1'b0, 3'd7, 32'h0000_0000, 32'd5,  32'h0000_0000, 1'b0, "pass_zero");
        run_op(1'b1, 3'd7, 32'h1234_5678, 32'd5,  32'h1234_5678, 1'b0, "pass_nz");
        run_op(1'b0, 3'd0, 32'hDEAD_BEEF, 32'd32, 32'hDEAD_BEEF, 1'b0, "shr_wrap32");
    endtask

    task automatic test_clear_and_ignore();
        bit saw_done;
        sel = 1'b0;
        @(negedge clock);
        op = 3'd0; a = 32'hFFFF_FFFF; b = 32'd20; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #2 clear = 1'b1;
        #1;
        checks++;
        if (result1 !== 32'd0 || busy1 !== 1'b0 || done1 !== 1'b0 || zero1 !== 1'b1) begin
            $display("FAIL clear_mid_run: got r=%h b=%b d=%b z=%b expected r=0 b=0 d=0 z=1", result1, busy1, done1, zero1);
            errors++;
        end
        @(negedge clock);
        clear = 1'b0;
        saw_done = 1'b0;
        repeat (30) begin
            @(posedge clock); #1;
            if (done1 || busy1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            $display("FAIL clear_abort: got activity=%b expected 0", saw_done);
            errors++;
        end
        run_op(1'b0, 3'd2, 32'h0000_0001, 32'd4, 32'h0000_0010, 1'b1, "start_in_run");
    endtask

    task automatic test_back_to_back();
        int edges;
        logic [31:0] e;
        int el;
        sel = 1'b1;
        @(negedge clock);
        op = 3'd2; a = 32'h0000_0001; b = 32'd31; start = 1'b1;
        exp_q.push_back(32'h8000_0000);
        lat_q.push_back(lat_of(3'd2, 32'd31, 4));
        @(posedge clock); #1;
        edges = 1;
        while (!done4 && edges < 200) begin
            @(posedge clock); #1;
            edges++;
        end
        e = exp_q.pop_front();
        el = lat_q.pop_front();
        checks++;
        if (done4 !== 1'b1 || result4 !== e || edges != el) begin
            $display("FAIL b2b_first: got done=%b r=%h lat=%0d expected done=1 r=%h lat=%0d", done4, result4, edges, e, el);
            errors++;
        end
        op = 3'd1; a = 32'h8000_0000; b = 32'd4;
        exp_q.push_back(32'hF800_0000);
        lat_q.push_back(lat_of(3'd1, 32'd4, 4));
        @(posedge clock); #1;
        start = 1'b0;
        checks++;
        if (busy4 !== 1'b1) begin
            $display("FAIL b2b_accept: got busy=%b expected 1", busy4);
            errors++;
        end
        edges = 1;
        while (!done4 && edges < 200) begin
            @(posedge clock); #1;
            edges++;
        end
        e = exp_q.pop_front();
        el = lat_q.pop_front();
        checks++;
        if (done4 !== 1'b1 || result4 !== e || edges != el) begin
            $display("FAIL b2b_second: got done=%b r=%h lat=%0d expected done=1 r=%h lat=%0d", done4, result4, edges, e, el);
            errors++;
        end
        @(posedge clock); #1;
        checks++;
        if (done4 !== 1'b0 || busy4 !== 1'b0) begin
            $display("FAIL b2b_idle: got done=%b busy=%b expected 0 0", done4, busy4);
            errors++;
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] x, y;
        for (int i = 0; i < 8; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            run_op(1'(i % 2), o, x, y, model(o, x, y), 1'b0, "random");
        end
    endtask

    initial begin
        #2;
        test_reset();
        @(negedge clock);
        clear = 1'b0;
        test_shifts();
        test_zero_count();
        test_clear_and_ignore();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
